// File: rtl/dpu_pkg.sv
// ---------------------------------------------------------------------------
// dpu_pkg
// Shared types and constants for the DPU datapath blocks.
//   int8_t      signed 8-bit activation/weight/result value
//   acc_t       signed accumulator/bias word (DPU_ACC_W bits)
//   pe_state_e  sequencer states of conv_pixel_engine
// ---------------------------------------------------------------------------
package dpu_pkg;

    localparam int DPU_ACC_W   = 32;
    localparam int LEAKY_SHIFT = 3;
    localparam int INT8_MAX    = 127;
    localparam int INT8_MIN    = -128;

    typedef logic signed [7:0]           int8_t;
    typedef logic signed [DPU_ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        BIAS,
        LEAKY,
        REQ,
        OUT
    } pe_state_e;

endpackage

// File: rtl/conv_pixel_engine_if.sv
// ---------------------------------------------------------------------------
// conv_pixel_engine_if
// Pair input stream and result output stream of conv_pixel_engine.
//   in_valid/in_ready/in_weight/in_act     (weight, activation) pair stream
//   out_valid/out_ready/out_data           int8 result stream
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The source holds valid and payload stable until that edge;
// the sink may raise or drop ready at any time.
// Modports: master = pair source / result sink, slave = the engine.
// ---------------------------------------------------------------------------
interface conv_pixel_engine_if;
    import dpu_pkg::*;

    logic  in_valid;
    logic  in_ready;
    int8_t in_weight;
    int8_t in_act;
    logic  out_valid;
    logic  out_ready;
    int8_t out_data;

    modport master (
        output in_valid, in_weight, in_act, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_weight, in_act, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pe_requant.sv
// ---------------------------------------------------------------------------
// pe_requant
// Combinational requantizer: p = y * scale (48-bit signed, scale unsigned),
// r = round-half-up(p / 2^SCALE_Q), then clamp to int8.
//   y      in   ACC_W  signed post-activation value
//   scale  in   16     unsigned Q(SCALE_Q) scale
//   data   out  8      clamped int8 result
//   sat    out  1      r fell outside [-128, 127] and was clamped
// ---------------------------------------------------------------------------
module pe_requant
    import dpu_pkg::*;
#(
    parameter int ACC_W   = DPU_ACC_W,
    parameter int SCALE_Q = 16
) (
    input  logic signed [ACC_W-1:0] y,
    input  logic        [15:0]      scale,
    output int8_t                   data,
    output logic                    sat
);

    localparam int P_W = 48;
    localparam logic signed [P_W-1:0] HALF  = P_W'(1) << (SCALE_Q - 1);
    localparam logic signed [P_W-1:0] R_MAX = P_W'(INT8_MAX);
    localparam logic signed [P_W-1:0] R_MIN = P_W'(INT8_MIN);

    logic signed [P_W-1:0] y_ext;
    logic signed [P_W-1:0] scale_ext;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] r;

    always_comb begin
        y_ext     = {{(P_W-ACC_W){y[ACC_W-1]}}, y};
        // Zero-extend so a scale above 0x7FFF is not read as negative.
        scale_ext = {{(P_W-16){1'b0}}, scale};
        prod      = y_ext * scale_ext;
        // All operands signed, so >>> floors toward minus infinity.
        r         = (prod + HALF) >>> SCALE_Q;
        sat       = 1'b0;
        data      = r[7:0];
        if (r > R_MAX) begin
            data = 8'(INT8_MAX);
            sat  = 1'b1;
        end else if (r < R_MIN) begin
            data = 8'(INT8_MIN);
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/conv_pixel_engine.sv
// ---------------------------------------------------------------------------
// conv_pixel_engine
// Sequencer for one conv output value: accumulates NUM_MACS int8 products,
// adds bias, applies LeakyReLU (negative slope 1/8) and requantizes to int8.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin a new output value; honoured only in IDLE
//   cfg_bias     signed bias, latched on an accepted start
//   cfg_scale    unsigned Q(SCALE_Q) scale, latched on an accepted start
//   bus          conv_pixel_engine_if.slave: pair input + result output
//   busy         state != IDLE
//   dbg_state    current sequencer state
//   sat_count    (CONV_PE_SAT_STATS_EN only) saturating count of clamped results
// Build option: define CONV_PE_SAT_STATS_EN to add sat_count.
// Timing: last pair accepted at edge N -> out_valid high after edge N+3.
// ---------------------------------------------------------------------------
module conv_pixel_engine
    import dpu_pkg::*;
#(
    parameter int NUM_MACS = 1152,
    parameter int SCALE_Q  = 16,
    parameter int ACC_W    = DPU_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] cfg_bias,
    input  logic        [15:0]      cfg_scale,
    conv_pixel_engine_if.slave      bus,
    output logic                    busy,
    output pe_state_e               dbg_state
`ifdef CONV_PE_SAT_STATS_EN
    ,
    output logic        [15:0]      sat_count
`endif
);

    localparam int CNT_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_MACS - 1);

    pe_state_e               state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] bias_q;
    logic        [15:0]      scale_q;
    logic        [CNT_W-1:0] count;

    logic signed [15:0]      prod;
    int8_t                   req_data;
    logic                    req_sat;

    // Full 16-bit signed product of two int8 values.
    assign prod = 16'(bus.in_weight) * 16'(bus.in_act);

    // acc is reused in place: sum -> sum+bias -> LeakyReLU(y) feeding requant.
    pe_requant #(
        .ACC_W   (ACC_W),
        .SCALE_Q (SCALE_Q)
    ) u_requant (
        .y     (acc),
        .scale (scale_q),
        .data  (req_data),
        .sat   (req_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            bias_q        <= '0;
            scale_q       <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
`ifdef CONV_PE_SAT_STATS_EN
            sat_count     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ACCUM;
                        acc          <= '0;
                        count        <= '0;
                        bias_q       <= cfg_bias;
                        scale_q      <= cfg_scale;
                        bus.in_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid && bus.in_ready) begin
                        acc   <= acc + ACC_W'(prod);
                        count <= count + CNT_W'(1);
                        if (count == LAST) begin
                            state        <= BIAS;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                BIAS: begin
                    acc   <= acc + bias_q;
                    state <= LEAKY;
                end
                LEAKY: begin
                    if (acc[ACC_W-1]) begin
                        acc <= acc >>> LEAKY_SHIFT;
                    end
                    state <= REQ;
                end
                REQ: begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= req_data;
`ifdef CONV_PE_SAT_STATS_EN
                    if (req_sat && (sat_count != 16'hFFFF)) begin
                        sat_count <= sat_count + 16'd1;
                    end
`endif
                    state <= OUT;
                end
                OUT: begin
                    // start is not looked at here, so a start coinciding
                    // with the result handshake is dropped.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CONV_PE_SAT_STATS_EN
    logic unused_sat;
    assign unused_sat = req_sat;
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_conv_pixel_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_pixel_engine
// Self-checking bench: a NUM_MACS=4 engine driven by a vector table, hand
// sequences and random operations; a NUM_MACS=1152 engine driven with four
// random back-to-back channels. Expected values come from constants or from
// an arithmetic reference model of the MAC/bias/LeakyReLU/requant rules.
// ---------------------------------------------------------------------------
module tb_conv_pixel_engine;
    import dpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic               s_start;
    logic signed [31:0] s_bias;
    logic        [15:0] s_scale;
    logic               s_busy;
    pe_state_e          s_state;

    logic               b_start;
    logic signed [31:0] b_bias;
    logic        [15:0] b_scale;
    logic               b_busy;
    pe_state_e          b_state;

`ifdef CONV_PE_SAT_STATS_EN
    logic [15:0] s_sat;
    logic [15:0] b_sat;
`endif

    conv_pixel_engine_if sif ();
    conv_pixel_engine_if bif ();

    conv_pixel_engine #(.NUM_MACS(4)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .cfg_bias  (s_bias),
        .cfg_scale (s_scale),
        .bus       (sif),
        .busy      (s_busy),
        .dbg_state (s_state)
`ifdef CONV_PE_SAT_STATS_EN
        ,
        .sat_count (s_sat)
`endif
    );

    conv_pixel_engine #(.NUM_MACS(1152)) dut_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .cfg_bias  (b_bias),
        .cfg_scale (b_scale),
        .bus       (bif),
        .busy      (b_busy),
        .dbg_state (b_state)
`ifdef CONV_PE_SAT_STATS_EN
        ,
        .sat_count (b_sat)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int s_exp_sat = 0;
    int b_exp_sat = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int model(input int wq[$], input int aq[$], input int bias,
                                 input int scale, output bit sat);
        int     x;
        longint y;
        longint r;
        x = 0;
        foreach (wq[i]) x += wq[i] * aq[i];   // int arithmetic wraps at 32 bits
        x += bias;
        y = (x >= 0) ? longint'(x) : floor_div(longint'(x), 8);
        r = floor_div(y * longint'(scale) + 32768, 65536);
        sat = (r > 127) || (r < -128);
        if (r > 127)  return 127;
        if (r < -128) return -128;
        return int'(r);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int w[4];
        int a[4];
        int bias;
        int scale;
        int exp;
        bit exp_sat;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int w0, input int w1, input int w2, input int w3,
                           input int a0, input int a1, input int a2, input int a3,
                           input int bias, input int scale, input int exp, input bit sat);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.bias = bias; v.scale = scale; v.exp = exp; v.exp_sat = sat;
        vq.push_back(v);
    endtask

    // ---------------- driver for the small engine ----------------
    // One full operation; checks latency, hold stability and the handshake.
    task automatic run_small(input int wq[$], input int aq[$], input int bias,
                             input int scale, input int gap, input int hold,
                             input bit poke, output int res);
        int lat;
        bit got;
        bit rdy;
        int held;
        res = 0;
        @(posedge clk); #1;
        s_start = 1'b1; s_bias = bias; s_scale = 16'(scale);
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < wq.size(); i++) begin
            for (int g = 0; g < gap; g++) begin
                s_start = poke; s_bias = 777; s_scale = 16'd1;
                @(posedge clk); #1;
                s_start = 1'b0;
            end
            sif.in_valid  = 1'b1;
            sif.in_weight = 8'(wq[i]);
            sif.in_act    = 8'(aq[i]);
            rdy = 1'b0;
            for (int k = 0; k < 10 && !rdy; k++) begin
                @(negedge clk);
                rdy = sif.in_ready;
                @(posedge clk); #1;
            end
            sif.in_valid = 1'b0;
            if (!rdy) check("in_ready_timeout", rdy, 1);
        end
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sif.out_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("out_valid_seen", got, 1);
        if (!got) return;
        check("latency", lat, 3);
        check("in_ready_in_out", sif.in_ready, 0);
        held = sif.out_data;
        res  = held;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            s_start = poke; s_bias = 555;
            @(negedge clk);
            check("hold_valid", sif.out_valid, 1);
            check("hold_data", sif.out_data, held);
            check("hold_in_ready", sif.in_ready, 0);
        end
        @(posedge clk); #1;
        sif.out_ready = 1'b1;
        s_start = poke;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        s_start = 1'b0;
        check("valid_drop", sif.out_valid, 0);
        check("busy_drop", s_busy, 0);
        check("data_kept", sif.out_data, held);
        if (poke) begin
            @(posedge clk); #1;
            check("start_ignored_at_handshake", s_busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wq[$];
        int aq[$];
        int res;
        int exp;
        bit sat;
        bit got;
        int bias;

        rst_n = 1'b1;
        s_start = 1'b0; s_bias = '0; s_scale = '0;
        b_start = 1'b0; b_bias = '0; b_scale = '0;
        sif.in_valid = 1'b0; sif.in_weight = '0; sif.in_act = '0; sif.out_ready = 1'b0;
        bif.in_valid = 1'b0; bif.in_weight = '0; bif.in_act = '0; bif.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", sif.in_ready, 0);
        check("reset_out_valid", sif.out_valid, 0);
        check("reset_out_data", sif.out_data, 0);
        check("reset_busy", s_busy, 0);
        check("reset_state", s_state, IDLE);
`ifdef CONV_PE_SAT_STATS_EN
        check("reset_sat_count", s_sat, 0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        add_vec(1, 2, 3, 4,       10, 10, 10, 10,          0,   655,    1, 0);
        add_vec(-1, -1, -1, -1,   100, 100, 100, 100,      0, 65535,  -50, 0);
        add_vec(127, 127, 127, 127, 127, 127, 127, 127,    0, 65535,  127, 1);
        add_vec(1, 1, 1, 1,       -128, -128, -128, -128,  0, 65535,  -64, 0);
        add_vec(0, 0, 0, 0,       0, 0, 0, 0,          -2000, 65535, -128, 1);
        add_vec(10, -20, 30, -40, 5, 5, 5, 5,            100, 40000,    0, 0);
        add_vec(0, 0, 0, 0,       0, 0, 0, 0,           1000, 32768,  127, 1);
        add_vec(0, 0, 0, 0,       0, 0, 0, 0,              3, 32768,    2, 0);
        add_vec(0, 0, 0, 0,       0, 0, 0, 0,             -3, 32768,    0, 0);
        add_vec(0, 0, 0, 0,       0, 0, 0, 0,             -9, 65535,   -2, 0);

        for (int i = 0; i < vq.size(); i++) begin
            wq = {}; aq = {};
            for (int j = 0; j < 4; j++) begin
                wq.push_back(vq[i].w[j]);
                aq.push_back(vq[i].a[j]);
            end
            run_small(wq, aq, vq[i].bias, vq[i].scale, 0, 0, 1'b0, res);
            check($sformatf("vec%0d_out_data", i), res, vq[i].exp);
            if (vq[i].exp_sat) s_exp_sat++;
`ifdef CONV_PE_SAT_STATS_EN
            check($sformatf("vec%0d_sat_count", i), s_sat, s_exp_sat);
`endif
        end

        // ---- stalls on both sides, start pulses while busy ----
        wq = '{1, 2, 3, 4};
        aq = '{10, 10, 10, 10};
        run_small(wq, aq, 0, 655, 2, 5, 1'b1, res);
        check("stall_out_data", res, 1);

        // ---- async reset mid-accumulation ----
        @(posedge clk); #1;
        s_start = 1'b1; s_bias = 0; s_scale = 16'd655;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sif.in_valid = 1'b1; sif.in_weight = 8'sd100; sif.in_act = 8'sd100;
            @(posedge clk); #1;
        end
        sif.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", sif.in_ready, 0);
        check("arst_out_valid", sif.out_valid, 0);
        check("arst_out_data", sif.out_data, 0);
        check("arst_busy", s_busy, 0);
        s_exp_sat = 0;
`ifdef CONV_PE_SAT_STATS_EN
        check("arst_sat_count", s_sat, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        wq = '{-1, -1, -1, -1};
        aq = '{100, 100, 100, 100};
        run_small(wq, aq, 0, 65535, 0, 0, 1'b0, res);
        check("after_reset_out_data", res, -50);

        // ---- random operations vs model ----
        for (int t = 0; t < 25; t++) begin
            int scale;
            wq = {}; aq = {};
            for (int j = 0; j < 4; j++) begin
                wq.push_back(int'($urandom_range(0, 255)) - 128);
                aq.push_back(int'($urandom_range(0, 255)) - 128);
            end
            bias  = int'($urandom_range(0, 40000)) - 20000;
            scale = int'($urandom_range(0, 4000));
            exp = model(wq, aq, bias, scale, sat);
            run_small(wq, aq, bias, scale, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), res);
            check($sformatf("rand%0d_out_data", t), res, exp);
            if (sat) s_exp_sat++;
`ifdef CONV_PE_SAT_STATS_EN
            check($sformatf("rand%0d_sat_count", t), s_sat, s_exp_sat);
`endif
        end

        // ---- full-size engine: four random channels back to back ----
        bif.out_ready = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            wq = {}; aq = {};
            for (int j = 0; j < 1152; j++) begin
                wq.push_back(int'($urandom_range(0, 255)) - 128);
                aq.push_back(int'($urandom_range(0, 255)) - 128);
            end
            bias = int'($urandom_range(0, 255)) - 128;
            exp  = model(wq, aq, bias, 655, sat);
            @(posedge clk); #1;
            b_start = 1'b1; b_bias = bias; b_scale = 16'd655;
            @(posedge clk); #1;
            b_start = 1'b0;
            for (int i = 0; i < 1152; i++) begin
                bit rdy;
                if ($urandom_range(0, 15) == 0) begin
                    @(posedge clk); #1;
                end
                bif.in_valid  = 1'b1;
                bif.in_weight = 8'(wq[i]);
                bif.in_act    = 8'(aq[i]);
                rdy = 1'b0;
                for (int k = 0; k < 10 && !rdy; k++) begin
                    @(negedge clk);
                    rdy = bif.in_ready;
                    @(posedge clk); #1;
                end
                bif.in_valid = 1'b0;
                if (!rdy) begin
                    check($sformatf("big_ch%0d_in_ready_timeout", ch), rdy, 1);
                    break;
                end
            end
            got = 1'b0;
            res = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bif.out_valid) begin
                    got = 1'b1;
                    res = bif.out_data;
                    break;
                end
            end
            check($sformatf("big_ch%0d_out_valid_seen", ch), got, 1);
            check($sformatf("big_ch%0d_out_data", ch), res, exp);
            if (sat) b_exp_sat++;
            @(posedge clk); #1;
            check($sformatf("big_ch%0d_idle_after", ch), b_busy, 0);
`ifdef CONV_PE_SAT_STATS_EN
            check($sformatf("big_ch%0d_sat_count", ch), b_sat, b_exp_sat);
`endif
        end
        bif.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
